// File: rtl/pixel_ctrl_pkg.sv
// Shared types and sizing for the pixel buffer controller.
// Defaults describe a 72-byte frame streamed ten times per run.
package pixel_ctrl_pkg;

    localparam int NUM_PIXELS_DEF = 72;
    localparam int NUM_PASSES_DEF = 10;
    localparam int PAIRS_DEF      = NUM_PIXELS_DEF / 2;
    localparam int PAIR_W         = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        PRESENT,
        SHIFT_A,
        SHIFT_B
    } state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up counter with clear, enable and programmable wrap value.
// Clear and enable together load 1, so a restart can count its first item.
module flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         count_enable,
    input  logic         clear,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count,
    output logic         rollover_flag
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] base;

    always_comb begin
        base    = clear ? '0 : count_q;
        count_d = base;
        if (count_enable) begin
            count_d = (base == rollover_val) ? '0 : base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count         = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/pixel_buffer_ctrl.sv
// Sequencer for the circular pixel shift buffer: SPI frame load,
// then pairwise streaming to the network for a number of full rotations.
module pixel_buffer_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int NUM_PASSES = NUM_PASSES_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_start,
    input  logic       spi_byte_valid,
    input  logic [7:0] spi_byte,
    input  logic       net_start,
    input  logic       net_pair_ack,
    output logic       shift_SPI,
    output logic       shift_network,
    output logic       write_en,
    output logic [7:0] spi_in,
    output logic       image_ready,
    output logic       pair_valid,
    output logic [5:0] pair_idx,
    output logic       pass_done,
    output logic       stream_done,
    output logic       err
);

    localparam int PAIRS  = NUM_PIXELS / 2;
    localparam int PIX_W  = cnt_w(NUM_PIXELS);
    localparam int PASS_W = cnt_w(NUM_PASSES - 1);

    state_t state_q;

    logic              ld_ok, byte_ok, refused, run_start;
    logic              pix_full, pair_last, pass_last;
    logic              pair_adv, pass_adv;
    logic [PIX_W-1:0]  pix_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic              unused_cnt;

    assign ld_ok     = load_start && (state_q inside {IDLE, READY, LOAD});
    assign byte_ok   = spi_byte_valid
                       && (ld_ok || (state_q == LOAD && !pix_full));
    assign refused   = (spi_byte_valid && !byte_ok)
                       || (load_start && !ld_ok);
    assign run_start = (state_q == READY) && net_start && !ld_ok;
    assign pair_adv  = (state_q == SHIFT_B);
    assign pass_adv  = pair_adv && pair_last;

    // Only the terminal flags of these two counters steer the FSM.
    assign unused_cnt = ^{pix_cnt, pass_cnt};

    flex_counter #(.W(PIX_W)) u_pix_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .count_enable (byte_ok),
        .clear        (ld_ok),
        .rollover_val (PIX_W'(NUM_PIXELS)),
        .count        (pix_cnt),
        .rollover_flag(pix_full)
    );

    flex_counter #(.W(PAIR_W)) u_pair_idx (
        .clk          (clk),
        .n_rst        (n_rst),
        .count_enable (pair_adv),
        .clear        (run_start),
        .rollover_val (PAIR_W'(PAIRS - 1)),
        .count        (pair_idx),
        .rollover_flag(pair_last)
    );

    flex_counter #(.W(PASS_W)) u_pass_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .count_enable (pass_adv),
        .clear        (run_start),
        .rollover_val (PASS_W'(NUM_PASSES - 1)),
        .count        (pass_cnt),
        .rollover_flag(pass_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            shift_SPI     <= 1'b0;
            shift_network <= 1'b0;
            write_en      <= 1'b0;
            spi_in        <= '0;
            image_ready   <= 1'b0;
            pair_valid    <= 1'b0;
            pass_done     <= 1'b0;
            stream_done   <= 1'b0;
            err           <= 1'b0;
        end else begin
            shift_SPI     <= byte_ok;
            write_en      <= byte_ok;
            spi_in        <= byte_ok ? spi_byte : '0;
            shift_network <= 1'b0;
            pass_done     <= 1'b0;
            stream_done   <= 1'b0;
            if (ld_ok) begin
                err <= 1'b0;
            end else if (refused) begin
                err <= 1'b1;
            end
            unique case (state_q)
                IDLE, READY: begin
                    if (ld_ok) begin
                        state_q     <= LOAD;
                        image_ready <= 1'b0;
                    end else if (run_start) begin
                        state_q     <= PRESENT;
                        image_ready <= 1'b0;
                        pair_valid  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!ld_ok && pix_full) begin
                        state_q     <= READY;
                        image_ready <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (net_pair_ack) begin
                        state_q       <= SHIFT_A;
                        pair_valid    <= 1'b0;
                        shift_network <= 1'b1;
                    end
                end
                SHIFT_A: begin
                    state_q       <= SHIFT_B;
                    shift_network <= 1'b1;
                end
                SHIFT_B: begin
                    state_q    <= PRESENT;
                    pair_valid <= 1'b1;
                    // A full rotation leaves the buffer back in load order.
                    if (pass_adv) begin
                        pass_done <= 1'b1;
                        if (pass_last) begin
                            state_q     <= READY;
                            pair_valid  <= 1'b0;
                            stream_done <= 1'b1;
                            image_ready <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_buffer_ctrl.sv
// Randomized bench for pixel_buffer_ctrl with a transaction-level model
// and an external 72-stage buffer driven by the DUT shift strobes.
module tb_pixel_buffer_ctrl;

    localparam int NP    = 72;
    localparam int NPASS = 10;
    localparam int PAIRS = NP / 2;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RDY  = 2;
    localparam int M_STRM = 3;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       load_start = 1'b0;
    logic       spi_byte_valid = 1'b0;
    logic [7:0] spi_byte = 8'h00;
    logic       net_start = 1'b0;
    logic       net_pair_ack = 1'b0;
    logic       shift_SPI, shift_network, write_en;
    logic [7:0] spi_in;
    logic       image_ready, pair_valid, pass_done, stream_done, err;
    logic [5:0] pair_idx;

    always #5 clk = ~clk;

    pixel_buffer_ctrl dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .load_start    (load_start),
        .spi_byte_valid(spi_byte_valid),
        .spi_byte      (spi_byte),
        .net_start     (net_start),
        .net_pair_ack  (net_pair_ack),
        .shift_SPI     (shift_SPI),
        .shift_network (shift_network),
        .write_en      (write_en),
        .spi_in        (spi_in),
        .image_ready   (image_ready),
        .pair_valid    (pair_valid),
        .pair_idx      (pair_idx),
        .pass_done     (pass_done),
        .stream_done   (stream_done),
        .err           (err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode, m_cnt, m_k, m_sub;
    logic       e_sspi, e_snet, e_ready, e_pv, e_pd, e_sd, e_err;
    logic [7:0] e_spi;
    logic [5:0] e_pidx;
    logic [7:0] frame [NP];
    logic [7:0] nf    [NP];
    logic       ld_ok, byte_ok, refuse;

    assign ld_ok   = load_start && (m_mode != M_STRM);
    assign byte_ok = spi_byte_valid
                     && (ld_ok || (m_mode == M_LOAD && m_cnt < NP));
    assign refuse  = (spi_byte_valid && !byte_ok) || (load_start && !ld_ok);
    assign e_pidx  = 6'(m_k % PAIRS);

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_mode  <= M_IDLE;
            m_cnt   <= 0;
            m_k     <= 0;
            m_sub   <= 0;
            e_sspi  <= 1'b0;
            e_snet  <= 1'b0;
            e_spi   <= 8'h00;
            e_ready <= 1'b0;
            e_pv    <= 1'b0;
            e_pd    <= 1'b0;
            e_sd    <= 1'b0;
            e_err   <= 1'b0;
        end else begin
            e_sspi <= byte_ok;
            e_spi  <= byte_ok ? spi_byte : 8'h00;
            e_snet <= 1'b0;
            e_pd   <= 1'b0;
            e_sd   <= 1'b0;
            if (ld_ok) e_err <= 1'b0;
            else if (refuse) e_err <= 1'b1;
            if (byte_ok) nf[ld_ok ? 0 : m_cnt] <= spi_byte;
            if (ld_ok) begin
                m_mode  <= M_LOAD;
                m_cnt   <= byte_ok ? 1 : 0;
                e_ready <= 1'b0;
            end else if (m_mode == M_LOAD) begin
                if (m_cnt == NP) begin
                    m_mode  <= M_RDY;
                    e_ready <= 1'b1;
                    for (int i = 0; i < NP; i++) frame[i] <= nf[i];
                end else if (byte_ok) begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (m_mode == M_RDY && net_start) begin
                m_mode  <= M_STRM;
                m_k     <= 0;
                m_sub   <= 0;
                e_ready <= 1'b0;
                e_pv    <= 1'b1;
            end else if (m_mode == M_STRM) begin
                case (m_sub)
                    0: if (net_pair_ack) begin
                        m_sub  <= 1;
                        e_pv   <= 1'b0;
                        e_snet <= 1'b1;
                    end
                    1: begin
                        m_sub  <= 2;
                        e_snet <= 1'b1;
                    end
                    default: begin
                        m_sub <= 0;
                        m_k   <= m_k + 1;
                        if ((m_k + 1) % PAIRS == 0) e_pd <= 1'b1;
                        if (m_k + 1 == PAIRS * NPASS) begin
                            e_sd    <= 1'b1;
                            e_ready <= 1'b1;
                            m_mode  <= M_RDY;
                        end else begin
                            e_pv <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- buffer + per-cycle compare ----------------
    logic [7:0] bufm [NP];
    int cnt_sspi = 0, cnt_snet = 0, cnt_pd = 0, cnt_sd = 0;

    always @(negedge clk) begin
        chk("shift_SPI", shift_SPI, e_sspi);
        chk("write_en", write_en, e_sspi);
        chk("spi_in", spi_in, e_spi);
        chk("shift_network", shift_network, e_snet);
        chk("image_ready", image_ready, e_ready);
        chk("pair_valid", pair_valid, e_pv);
        chk("pair_idx", pair_idx, e_pidx);
        chk("pass_done", pass_done, e_pd);
        chk("stream_done", stream_done, e_sd);
        chk("err", err, e_err);
        if (pair_valid === 1'b1) begin
            chk("tap_lo", bufm[0], frame[2 * int'(pair_idx)]);
            chk("tap_hi", bufm[1], frame[2 * int'(pair_idx) + 1]);
        end
        if (shift_SPI === 1'b1 || shift_network === 1'b1) begin
            for (int i = 0; i < NP - 1; i++) bufm[i] <= bufm[i + 1];
            bufm[NP - 1] <= (shift_SPI === 1'b1) ? spi_in : bufm[0];
        end
        if (shift_SPI === 1'b1) cnt_sspi <= cnt_sspi + 1;
        if (shift_network === 1'b1) cnt_snet <= cnt_snet + 1;
        if (pass_done === 1'b1) cnt_pd <= cnt_pd + 1;
        if (stream_done === 1'b1) cnt_sd <= cnt_sd + 1;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_load);
        spi_byte_valid = 1'b1;
        spi_byte       = b;
        load_start     = with_load;
        tick();
        spi_byte_valid = 1'b0;
        load_start     = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_bytes(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            send_byte(seq ? 8'(i) : 8'($urandom), 1'b0);
        end
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (image_ready !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk(name, image_ready, 1);
    endtask

    task automatic run_stream(input bit inject, input int stop_at,
                              output bit done);
        done      = 1'b0;
        net_start = 1'b1;
        tick();
        net_start = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (stop_at >= 0 && pair_valid === 1'b1
                && int'(pair_idx) == stop_at) break;
            net_pair_ack   = ($urandom_range(0, 2) == 0);
            spi_byte_valid = inject && (c == 0 || $urandom_range(0, 40) == 0);
            spi_byte       = 8'($urandom);
            load_start     = inject && $urandom_range(0, 150) == 0;
            tick();
            net_pair_ack   = 1'b0;
            spi_byte_valid = 1'b0;
            load_start     = 1'b0;
            if (stream_done === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit done;
        int s0, n0, p0, d0, bad;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #3;
        chk("rst_shift_SPI", shift_SPI, 0);
        chk("rst_image_ready", image_ready, 0);
        chk("rst_pair_valid", pair_valid, 0);
        chk("rst_pair_idx", pair_idx, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        tick();

        // frame of ascending bytes
        s0 = cnt_sspi;
        pulse_load();
        send_bytes(NP, 1'b1);
        wait_ready("t1_ready");
        chk("t1_spi_shifts", cnt_sspi - s0, NP);
        chk("t1_tap_lo", bufm[0], 8'h00);
        chk("t1_tap_hi", bufm[1], 8'h01);
        chk("t1_err", err, 0);

        // full streaming run
        n0 = cnt_snet; p0 = cnt_pd; d0 = cnt_sd;
        run_stream(1'b0, -1, done);
        tick();
        chk("t2_done", done, 1);
        chk("t2_net_shifts", cnt_snet - n0, NP * NPASS);
        chk("t2_pass_done", cnt_pd - p0, NPASS);
        chk("t2_stream_done", cnt_sd - d0, 1);
        chk("t2_ready", image_ready, 1);
        bad = 0;
        for (int i = 0; i < NP; i++) if (bufm[i] !== frame[i]) bad++;
        chk("t2_restored", bad, 0);

        // refused bytes and load_start while streaming
        s0 = cnt_sspi;
        run_stream(1'b1, -1, done);
        tick();
        chk("t3_done", done, 1);
        chk("t3_err", err, 1);
        chk("t3_no_spi_shift", cnt_sspi - s0, 0);

        // restart after 40 bytes
        pulse_load();
        chk("t4_err_clear", err, 0);
        send_bytes(40, 1'b0);
        pulse_load();
        send_bytes(NP - 1, 1'b0);
        tick();
        chk("t4_not_ready", image_ready, 0);
        send_bytes(1, 1'b0);
        wait_ready("t4_ready");

        // reset mid-pass
        run_stream(1'b0, 17, done);
        chk("t5_at_17", pair_idx, 17);
        #1 n_rst = 1'b0;
        #1;
        chk("t5_rst_pair_valid", pair_valid, 0);
        chk("t5_rst_pair_idx", pair_idx, 0);
        chk("t5_rst_image_ready", image_ready, 0);
        chk("t5_rst_shift_network", shift_network, 0);
        #3 n_rst = 1'b1;
        tick();
        net_start = 1'b1;
        tick();
        net_start = 1'b0;
        repeat (5) tick();
        chk("t5_net_ignored", pair_valid, 0);
        pulse_load();
        send_bytes(NP, 1'b0);
        wait_ready("t5_reload_ready");

        // load_start with same-cycle byte from READY
        s0 = cnt_sspi;
        send_byte(8'($urandom), 1'b1);
        send_bytes(NP - 1, 1'b0);
        wait_ready("t6_ready");
        chk("t6_spi_shifts", cnt_sspi - s0, NP);
        run_stream(1'b0, -1, done);
        tick();
        chk("t6_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
